// File: rtl/dmem_pkg.sv
// Shared types and access-decode helpers for the data-memory load/store unit.
// Helpers work on a 64-bit view; narrower datapaths use the low lanes.
package dmem_pkg;

    typedef enum logic [2:0] {
        F3_B   = 3'b000,
        F3_H   = 3'b001,
        F3_W   = 3'b010,
        F3_D   = 3'b011,
        F3_BU  = 3'b100,
        F3_HU  = 3'b101,
        F3_WU  = 3'b110,
        F3_ILL = 3'b111
    } funct3_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RESP = 2'd2
    } state_e;

    // log2 of the access size in bytes
    function automatic logic [1:0] access_size(input logic [2:0] f3);
        return f3[1:0];
    endfunction

    function automatic logic f3_legal(input logic [2:0] f3, input logic wide);
        logic ok;
        case (f3)
            F3_ILL:      ok = 1'b0;
            F3_D, F3_WU: ok = wide;
            default:     ok = 1'b1;
        endcase
        return ok;
    endfunction

    function automatic logic is_aligned(input logic [1:0] size, input logic [2:0] off);
        logic ok;
        case (size)
            2'd0:    ok = 1'b1;
            2'd1:    ok = (off[0] == 1'b0);
            2'd2:    ok = (off[1:0] == 2'b00);
            default: ok = (off == 3'b000);
        endcase
        return ok;
    endfunction

    function automatic logic [7:0] byte_en(input logic [1:0] size, input logic [2:0] off);
        logic [7:0] m;
        case (size)
            2'd0:    m = 8'h01;
            2'd1:    m = 8'h03;
            2'd2:    m = 8'h0f;
            default: m = 8'hff;
        endcase
        return m << off;
    endfunction

    // Shift the addressed lanes down to bit 0, then sign- or zero-extend.
    function automatic logic [63:0] load_extend(input logic [63:0] word,
                                                input logic [2:0]  off,
                                                input logic [2:0]  f3);
        logic [63:0] s;
        logic [63:0] r;
        s = word >> {off, 3'b000};
        case (f3[1:0])
            2'd0:    r = f3[2] ? {56'd0, s[7:0]}  : {{56{s[7]}},  s[7:0]};
            2'd1:    r = f3[2] ? {48'd0, s[15:0]} : {{48{s[15]}}, s[15:0]};
            2'd2:    r = f3[2] ? {32'd0, s[31:0]} : {{32{s[31]}}, s[31:0]};
            default: r = s;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_bank_ram.sv
// Byte-enabled single-port word RAM with a registered read port; contents
// are never reset.
module dmem_bank_ram #(
    parameter int AW     = 7,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                en,
    input  logic [DATA_W/8-1:0] be,
    input  logic [AW-1:0]       addr,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   rdata
);

    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] mem [0:(1 << AW) - 1];

    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (be[i]) begin
                mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
        if (en) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit: one request per handshake, one response per request,
// byte-lane decode and load extension in front of a synchronous RAM.
module dmem_lsu
    import dmem_pkg::*;
#(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [DM_ADDRESS-1:0] req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output state_e                dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high; req_ready never depends on req_valid, and rsp_valid and
    // the response payload stay constant until the edge where rsp_ready is high.

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int WAW   = DM_ADDRESS - OFF_W;

    state_e            state;
    logic [2:0]        f3_q;
    logic [2:0]        off_q;
    logic [2:0]        off3;
    logic [1:0]        size;
    logic              req_ok;
    logic              accept;
    logic [7:0]        be8;
    logic [NB-1:0]     ram_be;
    logic [DATA_W-1:0] wdata_sh;
    logic [DATA_W-1:0] ram_rdata;
    logic [63:0]       rd64;
    logic [63:0]       ext64;
    logic              unused_bits;

    always_comb begin
        off3 = '0;
        off3[OFF_W-1:0] = req_addr[OFF_W-1:0];
    end

    assign size      = access_size(req_funct3);
    assign req_ok    = f3_legal(req_funct3, DATA_W == 64) && is_aligned(size, off3);
    assign req_ready = (state == IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign be8       = byte_en(size, off3);
    assign wdata_sh  = req_wdata << {off3, 3'b000};

    // The store lands in the RAM on the acceptance edge itself.
    assign ram_be = (accept && req_we && req_ok) ? be8[NB-1:0] : '0;

    dmem_bank_ram #(
        .AW     (WAW),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .en    (accept),
        .be    (ram_be),
        .addr  (req_addr[DM_ADDRESS-1:OFF_W]),
        .wdata (wdata_sh),
        .rdata (ram_rdata)
    );

    always_comb begin
        rd64 = '0;
        rd64[DATA_W-1:0] = ram_rdata;
    end

    assign ext64       = load_extend(rd64, off_q, f3_q);
    assign unused_bits = ^{be8, ext64};
    assign dbg_state   = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            f3_q      <= '0;
            off_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        f3_q  <= req_funct3;
                        off_q <= off3;
                        if (!req_we && req_ok) begin
                            state <= LOAD;
                        end else begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= !req_ok;
                            rsp_rdata <= '0;
                        end
                    end
                end
                LOAD: begin
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= ext64[DATA_W-1:0];
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
